// File: rtl/idct2_transform_2d_pkg.sv
// Transform constants shared by the forward and inverse 8-point integer DCT blocks:
// the coefficient matrix, default pass shifts, clip bounds and the 2-D controller states.
package idct2_transform_2d_pkg;

  localparam int N          = 8;
  localparam int ACC_W      = 32;
  localparam int SHIFT1_DEF = 7;
  localparam int SHIFT2_DEF = 12;

  localparam int CLIP1_MIN = -32768;
  localparam int CLIP1_MAX = 32767;
  localparam int CLIP2_MIN = -128;
  localparam int CLIP2_MAX = 127;

  // C[k][n]: row k is basis function k sampled at position n
  localparam int C_MAT [N][N] = '{
    '{ 64,  64,  64,  64,  64,  64,  64,  64},
    '{ 89,  75,  50,  18, -18, -50, -75, -89},
    '{ 83,  36, -36, -83, -83, -36,  36,  83},
    '{ 75, -18, -89, -50,  50,  89,  18, -75},
    '{ 64, -64, -64,  64,  64, -64, -64,  64},
    '{ 50, -89,  18,  75, -75, -18,  89, -50},
    '{ 36, -83,  83, -36, -36,  83, -83,  36},
    '{ 18, -50,  75, -89,  89, -75,  50, -18}
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/idct_1d.sv
// Combinational 8-point inverse DCT: out[n] = sum_k C[k][n]*in[k], rounded, shifted and clipped.
// pass_sel_i picks the second shift/clip set so one instance serves both 2-D passes.
module idct_1d
  import idct2_transform_2d_pkg::*;
#(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16,
  parameter int SHIFT_A    = SHIFT1_DEF,
  parameter int SHIFT_B    = SHIFT2_DEF,
  parameter int CLIP_A_MIN = CLIP1_MIN,
  parameter int CLIP_A_MAX = CLIP1_MAX,
  parameter int CLIP_B_MIN = CLIP2_MIN,
  parameter int CLIP_B_MAX = CLIP2_MAX
) (
  input  logic                    pass_sel_i,
  input  logic signed [IN_W-1:0]  in_i  [N],
  output logic signed [OUT_W-1:0] out_o [N]
);

  localparam int RND_A = 1 << (SHIFT_A - 1);
  localparam int RND_B = 1 << (SHIFT_B - 1);

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rnd;
    int lo;
    int hi;

    always_comb begin
      acc = '0;
      for (int k = 0; k < N; k++) begin
        acc = acc + C_MAT[k][gi] * ACC_W'(in_i[k]);
      end
      rnd = (acc + RND_A) >>> SHIFT_A;
      lo  = CLIP_A_MIN;
      hi  = CLIP_A_MAX;
      if (pass_sel_i) begin
        rnd = (acc + RND_B) >>> SHIFT_B;
        lo  = CLIP_B_MIN;
        hi  = CLIP_B_MAX;
      end
      if (rnd < lo) begin
        out_o[gi] = OUT_W'(lo);
      end else if (rnd > hi) begin
        out_o[gi] = OUT_W'(hi);
      end else begin
        out_o[gi] = rnd[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/idct2_transform_2d.sv
// 8x8 2-D inverse DCT: row pass into a transpose buffer, then column pass into Y.
// One shared 1-D unit; Y is replaced as a whole when the block completes.
module idct2_transform_2d
  import idct2_transform_2d_pkg::*;
#(
  parameter int SHIFT1 = SHIFT1_DEF,
  parameter int SHIFT2 = SHIFT2_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] X,
  output logic         busy,
  output logic         ready,
  output logic [511:0] Y
);

  state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [511:0] x_q;
  logic [511:0] y_q;
  logic [511:0] y_work_q, y_work_d;
  logic         col_vld_q;
  logic [2:0]   wr_col;

  logic signed [15:0] tbuf_q   [N][N];
  logic signed [15:0] col_q    [N];
  logic signed [15:0] row_elem [N];
  logic signed [15:0] unit_in  [N];
  logic signed [15:0] unit_out [N];

  // Column reads from the transpose buffer are registered, so each column is
  // processed one cycle after its read and written to column cnt_q-1.
  assign wr_col = cnt_q - 3'd1;

  for (genvar gi = 0; gi < N; gi++) begin : g_in
    logic [7:0] xe;
    assign xe           = x_q[64*int'(cnt_q) + 8*(7-gi) +: 8];
    assign row_elem[gi] = {{8{xe[7]}}, xe};
    assign unit_in[gi]  = (state_q == PASS2) ? col_q[gi] : row_elem[gi];
  end

  idct_1d #(
    .IN_W       (16),
    .OUT_W      (16),
    .SHIFT_A    (SHIFT1),
    .SHIFT_B    (SHIFT2),
    .CLIP_A_MIN (CLIP1_MIN),
    .CLIP_A_MAX (CLIP1_MAX),
    .CLIP_B_MIN (CLIP2_MIN),
    .CLIP_B_MAX (CLIP2_MAX)
  ) u_idct_1d (
    .pass_sel_i (state_q == PASS2),
    .in_i       (unit_in),
    .out_o      (unit_out)
  );

  always_comb begin
    y_work_d = y_work_q;
    for (int r = 0; r < N; r++) begin
      y_work_d[64*r + 8*(7-int'(wr_col)) +: 8] = unit_out[r][7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PASS1;
          cnt_d   = 3'd0;
        end
      end
      PASS1: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = PASS2;
      end
      PASS2: begin
        cnt_d = cnt_q + 3'd1;
        if (col_vld_q && cnt_q == 3'd0) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end
      end
      DONE: begin
        cnt_d   = 3'd0;
        state_d = start ? PASS1 : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      y_work_q  <= '0;
      col_vld_q <= 1'b0;
      for (int r = 0; r < N; r++) begin
        col_q[r] <= '0;
        for (int c = 0; c < N; c++) tbuf_q[r][c] <= '0;
      end
    end else begin
      if ((state_q == IDLE || state_q == DONE) && start) x_q <= X;
      if (state_q == PASS1) begin
        col_vld_q <= 1'b0;
        for (int c = 0; c < N; c++) tbuf_q[cnt_q][c] <= unit_out[c];
      end
      if (state_q == PASS2) begin
        col_vld_q <= 1'b1;
        for (int r = 0; r < N; r++) col_q[r] <= tbuf_q[r][cnt_q];
        if (col_vld_q) begin
          y_work_q <= y_work_d;
          if (cnt_q == 3'd0) y_q <= y_work_d;
        end
      end
    end
  end

  assign busy  = (state_q == PASS1) || (state_q == PASS2);
  assign ready = (state_q == DONE);
  assign Y     = y_q;

endmodule
